// File: rtl/uart_prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_pkg
// Description : Shared types and constants for the UART program loader.
//               loader_state_t  - loader FSM state encoding
//               SYNC_BYTE       - frame start marker
//               LEN_BYTES       - number of length-prefix bytes
// Revision    : 1.0 - initial release
// ============================================================================
package uart_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } loader_state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned LEN_BYTES = 2;

endpackage : uart_prog_pkg
`default_nettype wire

// File: rtl/uart_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader_if
// Description : Byte-stream input and imem programming port of the loader.
//               rx_data/rx_valid/rx_err       - received byte stream
//               uart_dout/memcon_prog_ena/
//               prog_addr                     - imem write port
//               slave  : the loader (consumes bytes, drives writes)
//               master : the surrounding system (drives bytes, takes writes)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_prog_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [31:0] uart_dout;
  logic        memcon_prog_ena;
  logic [31:0] prog_addr;

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_err,
    output uart_dout,
    output memcon_prog_ena,
    output prog_addr
  );

  modport master (
    output rx_data,
    output rx_valid,
    output rx_err,
    input  uart_dout,
    input  memcon_prog_ena,
    input  prog_addr
  );

endinterface : uart_prog_loader_if
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader
// Description : Consumes a length-prefixed byte frame (A5, N lo, N hi, N*4
//               data bytes, little-endian words) and writes each assembled
//               word to instruction memory with a one-cycle strobe.
// Ports       : clk        - system clock, rising edge
//               Rst        - asynchronous active-low reset
//               prog       - loader enable (level)
//               bus        - byte input + imem write port (slave modport)
//               busy       - frame in progress (LEN or DATA)
//               done / err - sticky result of the last frame
//               word_cnt   - words written in current/last frame
// Revision    : 1.0 - initial release
// ============================================================================
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               prog,
  uart_prog_loader_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        word_cnt
);

  localparam logic [1:0] c_len_last  = 2'(LEN_BYTES - 1);
  localparam logic [1:0] c_lane_last = 2'd3;

  loader_state_t r_state;
  loader_state_t w_next_state;

  logic [15:0] r_len;
  logic [1:0]  r_idx;
  logic [23:0] r_asm;        // lanes 0..2; lane 3 comes straight from rx_data
  logic [31:0] r_dout;
  logic [31:0] r_addr;
  logic        r_ena;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_word_cnt;

  logic        w_start;
  logic        w_len_cap;
  logic        w_lane_cap;
  logic        w_strobe;
  logic        w_prog_abort;
  logic [15:0] w_len_full;
  logic [15:0] w_cnt_inc;

  assign w_len_full = {bus.rx_data, r_len[7:0]};
  assign w_cnt_inc  = r_word_cnt + 16'd1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // Loss of prog dominates everything; a byte flagged with rx_err is never
  // used, it only aborts an in-progress frame.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_len_cap    = 1'b0;
    w_lane_cap   = 1'b0;
    w_strobe     = 1'b0;
    w_prog_abort = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (prog && bus.rx_valid && !bus.rx_err && (bus.rx_data == SYNC_BYTE)) begin
          w_next_state = ST_LEN;
          w_start      = 1'b1;
        end
      end

      ST_LEN: begin
        if (!prog) begin
          w_next_state = ST_IDLE;
          w_prog_abort = 1'b1;
        end else if (bus.rx_err) begin
          w_next_state = ST_ERR;
        end else if (bus.rx_valid) begin
          w_len_cap = 1'b1;
          if (r_idx == c_len_last) begin
            if ((w_len_full == 16'd0) || (w_len_full > 16'(MAX_WORDS))) begin
              w_next_state = ST_ERR;
            end else begin
              w_next_state = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        if (!prog) begin
          w_next_state = ST_IDLE;
          w_prog_abort = 1'b1;
        end else if (bus.rx_err) begin
          w_next_state = ST_ERR;
        end else if (bus.rx_valid) begin
          if (r_idx == c_lane_last) begin
            w_strobe = 1'b1;
            if (w_cnt_inc == r_len) begin
              w_next_state = ST_DONE;
            end
          end else begin
            w_lane_cap = 1'b1;
          end
        end
      end

      ST_DONE: w_next_state = ST_IDLE;
      ST_ERR:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: length capture, word assembly, write port, status flags.
  // done/err are set while in DONE/ERR so that done appears the cycle after
  // the final strobe rather than alongside it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_len      <= 16'd0;
      r_idx      <= 2'd0;
      r_asm      <= 24'd0;
      r_dout     <= 32'd0;
      r_addr     <= BASE_ADDR;
      r_ena      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_word_cnt <= 16'd0;
    end else begin
      r_ena <= 1'b0;

      if (w_start) begin
        r_idx      <= 2'd0;
        r_word_cnt <= 16'd0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
      end

      if (w_len_cap) begin
        if (r_idx == 2'd0) begin
          r_len[7:0] <= bus.rx_data;
        end else begin
          r_len[15:8] <= bus.rx_data;
        end
        r_idx <= (r_idx == c_len_last) ? 2'd0 : r_idx + 2'd1;
      end

      if (w_lane_cap) begin
        case (r_idx)
          2'd0:    r_asm[7:0]   <= bus.rx_data;
          2'd1:    r_asm[15:8]  <= bus.rx_data;
          default: r_asm[23:16] <= bus.rx_data;
        endcase
        r_idx <= r_idx + 2'd1;
      end

      if (w_strobe) begin
        r_dout     <= {bus.rx_data, r_asm};
        r_addr     <= BASE_ADDR + {14'd0, r_word_cnt, 2'b00};
        r_ena      <= 1'b1;
        r_word_cnt <= w_cnt_inc;
        r_idx      <= 2'd0;
      end

      if (r_state == ST_DONE) begin
        r_done <= 1'b1;
      end
      if ((r_state == ST_ERR) || w_prog_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.uart_dout       = r_dout;
  assign bus.memcon_prog_ena = r_ena;
  assign bus.prog_addr       = r_addr;
  assign busy                = (r_state == ST_LEN) || (r_state == ST_DATA);
  assign done                = r_done;
  assign err                 = r_err;
  assign word_cnt            = r_word_cnt;

endmodule : uart_prog_loader
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_prog_loader
// Description : Directed self-checking bench for uart_prog_loader
//               (BASE_ADDR = 0, MAX_WORDS = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_prog_loader;

  logic        clk;
  logic        Rst;
  logic        prog;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] word_cnt;

  uart_prog_loader_if bus();

  uart_prog_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (4)
  ) dut (
    .clk      (clk),
    .Rst      (Rst),
    .prog     (prog),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // strobe recorder, sampled mid-cycle
  logic [31:0] s_addr[$];
  logic [31:0] s_data[$];
  int          s_cyc[$];
  int          l3_cyc[$];
  int          last_cyc;

  always @(negedge clk) begin
    if (bus.memcon_prog_ena) begin
      s_addr.push_back(bus.prog_addr);
      s_data.push_back(bus.uart_dout);
      s_cyc.push_back(cyc);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic clear_log();
    s_addr.delete();
    s_data.delete();
    s_cyc.delete();
    l3_cyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic e, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.rx_err   = e;
    @(posedge clk);
    #1;
    last_cyc     = cyc;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send(w[8*i +: 8], 1'b0, gap);
      if (i == 3) l3_cyc.push_back(last_cyc);
    end
  endtask

  task automatic send_hdr(input logic [15:0] n, input int gap);
    send(8'hA5, 1'b0, gap);
    send(n[7:0], 1'b0, gap);
    send(n[15:8], 1'b0, gap);
  endtask

  // Compare the recorded writes against consecutive word addresses from 0.
  logic [31:0] exp_w[$];
  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, s_addr.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < s_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), s_addr[i], 32'(i * 4));
      check($sformatf("%s_data%0d", tag, i), s_data[i], exp_w[i]);
      if (i < l3_cyc.size())
        check($sformatf("%s_lat%0d", tag, i), s_cyc[i], l3_cyc[i]);
    end
  endtask

  initial begin
    Rst          = 1'b0;
    prog         = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    last_cyc     = 0;

    // ---------------- reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout", bus.uart_dout, 32'h0);
    check("rst_ena",  bus.memcon_prog_ena, 32'h0);
    check("rst_addr", bus.prog_addr, 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_done", done, 32'h0);
    check("rst_err",  err, 32'h0);
    check("rst_cnt",  word_cnt, 32'h0);
    @(posedge clk);
    #1;
    Rst  = 1'b1;
    prog = 1'b1;
    tick(2);

    // ---------------- clean 3-word frame with idle gaps
    clear_log();
    exp_w = '{32'h0000_0013, 32'h0010_0093, 32'hDEAD_BEEF};
    send_hdr(16'd3, 2);
    check("t1_busy", busy, 32'h1);
    send_word(32'h0000_0013, 2);
    send_word(32'h0010_0093, 2);
    for (int i = 0; i < 3; i++) send(8'(32'hDEAD_BEEF >> (8 * i)), 1'b0, 1);
    send(8'hDE, 1'b0, 0);
    l3_cyc.push_back(last_cyc);
    @(negedge clk);
    check("t1_ena_last", bus.memcon_prog_ena, 32'h1);
    check("t1_done_early", done, 32'h0);
    @(negedge clk);
    check("t1_ena_width", bus.memcon_prog_ena, 32'h0);
    check("t1_done", done, 32'h1);
    tick(3);
    check_writes("t1");
    check("t1_done_sticky", done, 32'h1);
    check("t1_err", err, 32'h0);
    check("t1_cnt", word_cnt, 32'd3);
    check("t1_busy_end", busy, 32'h0);
    check("t1_hold_data", bus.uart_dout, 32'hDEAD_BEEF);
    check("t1_hold_addr", bus.prog_addr, 32'h8);

    // ---------------- same frame, rx_valid every cycle
    clear_log();
    send(8'hA5, 1'b0, 0);
    check("t2_done_clr", done, 32'h0);
    send(8'h03, 1'b0, 0);
    send(8'h00, 1'b0, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    send_word(32'hDEAD_BEEF, 0);
    tick(4);
    check_writes("t2");
    check("t2_done", done, 32'h1);
    check("t2_cnt", word_cnt, 32'd3);

    // ---------------- length bounds
    clear_log();
    exp_w.delete();
    send_hdr(16'd5, 0);
    tick(3);
    check("t3_n5_err", err, 32'h1);
    check("t3_n5_done", done, 32'h0);
    check("t3_n5_nwr", s_addr.size(), 32'd0);
    send_hdr(16'd0, 0);
    tick(3);
    check("t3_n0_err", err, 32'h1);
    check("t3_n0_nwr", s_addr.size(), 32'd0);
    check("t3_n0_busy", busy, 32'h0);
    send_hdr(16'd4, 0);
    check("t3_n4_busy", busy, 32'h1);
    check("t3_n4_err_clr", err, 32'h0);
    prog = 1'b0;
    tick(2);
    prog = 1'b1;

    // ---------------- framing error on data byte 6
    clear_log();
    exp_w = '{32'h1122_3344};
    send_hdr(16'd3, 1);
    send_word(32'h1122_3344, 1);
    send(8'h55, 1'b0, 1);
    send(8'h66, 1'b0, 1);
    send(8'h77, 1'b1, 1);
    send(8'h88, 1'b0, 1);
    tick(3);
    check_writes("t4");
    check("t4_err", err, 32'h1);
    check("t4_done", done, 32'h0);
    check("t4_cnt", word_cnt, 32'd1);

    // ---------------- loss of prog after word 1 of 4
    clear_log();
    exp_w = '{32'hA0A1_A2A3, 32'hB0B1_B2B3};
    send_hdr(16'd4, 0);
    send_word(32'hA0A1_A2A3, 0);
    send_word(32'hB0B1_B2B3, 0);
    prog = 1'b0;
    tick(2);
    send_word(32'hC0C1_C2C3, 0);
    send(8'hA5, 1'b0, 0);
    tick(3);
    check_writes("t5");
    check("t5_err", err, 32'h1);
    check("t5_busy", busy, 32'h0);
    check("t5_cnt", word_cnt, 32'd2);
    clear_log();
    exp_w = '{32'hCAFE_F00D};
    prog = 1'b1;
    send(8'hA5, 1'b0, 0);
    @(negedge clk);
    check("t5_err_clr", err, 32'h0);
    check("t5_busy_new", busy, 32'h1);
    @(posedge clk);
    #1;
    send(8'h01, 1'b0, 0);
    send(8'h00, 1'b0, 0);
    send_word(32'hCAFE_F00D, 0);
    tick(3);
    check_writes("t5b");
    check("t5b_done", done, 32'h1);

    // ---------------- reset mid-frame with a strobe pending
    clear_log();
    send_hdr(16'd2, 0);
    for (int i = 0; i < 3; i++) send(8'h10 + 8'(i), 1'b0, 0);
    bus.rx_data  = 8'h13;
    bus.rx_valid = 1'b1;
    Rst          = 1'b0;
    @(negedge clk);
    check("t6_ena", bus.memcon_prog_ena, 32'h0);
    check("t6_dout", bus.uart_dout, 32'h0);
    check("t6_addr", bus.prog_addr, 32'h0);
    check("t6_busy", busy, 32'h0);
    check("t6_done", done, 32'h0);
    check("t6_cnt", word_cnt, 32'h0);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    Rst          = 1'b1;
    tick(1);
    send(8'h00, 1'b0, 0);
    send(8'h13, 1'b0, 0);
    send(8'hFF, 1'b0, 0);
    send(8'h5A, 1'b0, 0);
    tick(2);
    check("t6_stray_busy", busy, 32'h0);
    check("t6_stray_nwr", s_addr.size(), 32'd0);
    check("t6_stray_err", err, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_uart_prog_loader
`default_nettype wire

// File: doc/uart_prog_loader.md
# uart_prog_loader

Byte-stream program loader sitting directly upstream of the reprogrammable fetch stage. It consumes bytes from the UART receiver while `prog` is high, assembles them into 32-bit little-endian instruction words, and drives the instruction-memory programming port (`uart_dout`, `memcon_prog_ena`, `prog_addr`) with one write strobe per word. The frame is length-prefixed, bounds-checked against a maximum image size, and ends with status flags the host side can poll.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written.
- `MAX_WORDS`, default 1024: largest accepted image size in words. Must be 1..65535.
- `clk` in 1: system clock; all logic is on its rising edge.
- `Rst` in 1: reset, asynchronous, active-low.
- `prog` in 1: loader enable, level-sensitive. The core pipeline is held while this is high.
- `rx_data` in 8: received byte; valid only when `rx_valid` is high.
- `rx_valid` in 1: one-cycle strobe per received byte. May be high on consecutive cycles.
- `rx_err` in 1: UART framing error strobe for the current byte.
- `uart_dout` out 32: assembled instruction word; this is the imem write data.
- `memcon_prog_ena` out 1: one-cycle imem write strobe.
- `prog_addr` out 32: imem byte address for the current write.
- `busy` out 1: a frame is in progress (state LEN or DATA).
- `done` out 1: the last frame completed cleanly; sticky until the next frame starts.
- `err` out 1: the last frame aborted; sticky until the next frame starts.
- `word_cnt` out 16: number of words written in the current or last frame.

## Operation
- **Frame format:**
  - Sync byte 8'hA5.
  - Length N, 2 bytes, LSB first. N is a count of words.
  - N×4 data bytes, each word LSB first.
- **States:** IDLE, LEN, DATA, DONE, ERR.
- **IDLE:**
  - Ignores every byte except 8'hA5.
  - On A5 with `prog`=1: go to LEN; clear `done`, `err`, `word_cnt` and the byte index.
- **LEN:**
  - Capture 2 bytes into N.
  - If N=0 or N>`MAX_WORDS`: go to ERR.
  - Otherwise go to DATA.
- **DATA:**
  - Shift bytes into a 32-bit assembly register at byte lane `idx` (0..3).
  - After lane 3, on the next cycle:
    - `uart_dout` = the assembled word.
    - `prog_addr` = `BASE_ADDR` + 4·`word_cnt`.
    - `memcon_prog_ena` = 1.
    - `word_cnt` increments in the same cycle as the strobe.
  - When `word_cnt` reaches N, go to DONE.
- **DONE:** `done`=1. Return to IDLE on the next cycle.
- **ERR:** `err`=1. Return to IDLE on the next cycle.
- **Abort conditions:** `rx_err` in LEN or DATA → ERR. No further writes occur.
- **`prog` falling:** from any state other than IDLE, `prog` going low → IDLE with `err`=1 if a frame was in progress. No further strobes are issued after the cycle `prog` is sampled low.
- **Arithmetic:**
  - `word_cnt` is 16-bit and never wraps, because N ≤ `MAX_WORDS` ≤ 65535.
  - `prog_addr` is computed modulo 2^32.
- **Partial words:** a partial word left when a frame aborts is discarded.

## Timing
- **Reset values:** state IDLE; `uart_dout`=0, `memcon_prog_ena`=0, `prog_addr`=`BASE_ADDR`, `busy`=0, `done`=0, `err`=0, `word_cnt`=0.
- **Write latency:** `memcon_prog_ena` rises exactly 1 cycle after the `rx_valid` carrying byte lane 3, and lasts 1 cycle. `uart_dout` and `prog_addr` are stable during the strobe and hold until the next strobe.
- **Back-to-back bytes:** byte lane 0 of the next word may arrive in the same cycle as the previous word's strobe. It must be captured without loss.
- **`done` timing:** `done` rises 1 cycle after the final strobe. It does not rise in the same cycle as the strobe.
- **Simultaneous events:**
  - `rx_err` together with `rx_valid`: the byte is discarded and the frame goes to ERR.
  - `prog` low together with `rx_valid`: the byte is ignored.
- **Reset mid-frame:** any in-flight strobe is cancelled immediately and all outputs return to their reset values.

## Structure
- Shared package `uart_prog_pkg`:
  - state enum `loader_state_t`.
  - `SYNC_BYTE` = 8'hA5.
  - `LEN_BYTES` = 2.
- The module is a single flat FSM; no sub-module is needed.
- The UART receiver (`uart_rx`) is a separate existing block and is instantiated by the parent, not by this module.

## Test plan
- **Clean 3-word frame:** A5,03,00 then words 0x00000013, 0x00100093, 0xDEADBEEF (LSB first) → 3 strobes, `prog_addr` 0x0/0x4/0x8 with matching data, `done`=1, `word_cnt`=3.
- **Back-to-back bytes:** the same frame with `rx_valid` high every cycle → identical writes; strobe 1 cycle after each lane 3; no lost bytes.
- **Length bounds, `MAX_WORDS`=4:**
  - N=5 → ERR, `err`=1, zero strobes.
  - N=0 → ERR, `err`=1, zero strobes.
- **Framing error mid-word:** `rx_err` on data byte 6 → `err`=1, exactly 1 strobe issued (word 0), `word_cnt`=1.
- **Loss of `prog`:** `prog` deasserted after word 1 of 4 → IDLE, `err`=1, no further strobes. A new A5 frame then clears `err` and loads from `BASE_ADDR`.
- **Reset mid-frame:** `Rst` low in the same cycle as a pending strobe → strobe suppressed, all outputs at reset values; stray non-A5 bytes in IDLE are ignored.
